// File: rtl/fib_pkg.sv
// Shared state type and Fibonacci group arithmetic for fibonacci_stream.
// Terms travel at MAX_W bits so a single function serves every instance width.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fib_state_e;

    localparam int IDX_W     = 16;
    localparam int MAX_W     = 64;
    localparam int MAX_LANES = 8;

    typedef struct packed {
        logic [MAX_LANES+1:0][MAX_W-1:0] term;
        logic [MAX_LANES+1:0]            ovf;
    } fib_group_t;

    // Extends term[0], term[1] to term[lanes+1]; each sum gets one extra bit to catch the carry,
    // and overflow is inherited from either operand so it never clears once set.
    function automatic fib_group_t fib_group(
        input logic [MAX_W-1:0] t0,
        input logic [MAX_W-1:0] t1,
        input logic             o0,
        input logic             o1,
        input int               w,
        input int               lanes
    );
        fib_group_t     g;
        logic [MAX_W:0] limit;
        logic [MAX_W:0] sum;
        limit     = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        sum       = '0;
        g         = '0;
        g.term[0] = t0;
        g.term[1] = t1;
        g.ovf[0]  = o0;
        g.ovf[1]  = o1;
        for (int k = 2; k < MAX_LANES + 2; k++) begin
            if (k < lanes + 2) begin
                sum       = {1'b0, g.term[k-1]} + {1'b0, g.term[k-2]};
                g.ovf[k]  = g.ovf[k-1] | g.ovf[k-2] | (sum > limit);
                g.term[k] = sum[MAX_W-1:0] & limit[MAX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fib_group_adder.sv
// Combinational adder chain: from two consecutive terms, produce one LANES-wide group
// plus the two terms that start the following group.
module fib_group_adder
    import fib_pkg::*;
#(
    parameter int W     = 16,
    parameter int LANES = 2
) (
    input  logic [W-1:0]       t0,
    input  logic [W-1:0]       t1,
    input  logic               o0,
    input  logic               o1,
    output logic [LANES*W-1:0] lane_term,
    output logic [LANES-1:0]   lane_ovf,
    output logic [W-1:0]       nxt_t0,
    output logic [W-1:0]       nxt_t1,
    output logic               nxt_o0,
    output logic               nxt_o1
);

    fib_group_t grp;
    logic       unused_grp;

    always_comb begin
        grp = fib_group(MAX_W'(t0), MAX_W'(t1), o0, o1, W, LANES);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_term[i*W +: W] = grp.term[i][W-1:0];
        assign lane_ovf[i]         = grp.ovf[i];
    end

    assign nxt_t0     = grp.term[LANES][W-1:0];
    assign nxt_t1     = grp.term[LANES+1][W-1:0];
    assign nxt_o0     = grp.ovf[LANES];
    assign nxt_o1     = grp.ovf[LANES+1];
    assign unused_grp = ^grp;

endmodule

// File: rtl/fibonacci_stream.sv
// Fibonacci source with a valid/ready group stream: LANES terms per transfer,
// wrapping with a sticky flag or stopping at the first overflowing term.
module fibonacci_stream
    import fib_pkg::*;
#(
    parameter int W           = 16,
    parameter int LANES       = 2,
    parameter int STOP_ON_OVF = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       seed0,
    input  logic [W-1:0]       seed1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_idx,
    output logic               ovf
);

    localparam bit STOP = (STOP_ON_OVF != 0);

    fib_state_e         state_q, state_d;
    logic               valid_q, valid_d;
    logic [LANES*W-1:0] data_q, data_d;
    logic [LANES-1:0]   keep_q, keep_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic [W-1:0]       n0_q, n0_d, n1_q, n1_d;
    logic               n0_ovf_q, n0_ovf_d, n1_ovf_q, n1_ovf_d;

    logic               fire, load_first, load_next;
    logic [W-1:0]       add_t0, add_t1;
    logic               add_o0, add_o1;
    logic [LANES*W-1:0] lane_term;
    logic [LANES-1:0]   lane_ovf;
    logic [W-1:0]       nxt_t0, nxt_t1;
    logic               nxt_o0, nxt_o1;
    logic [LANES-1:0]   grp_keep;
    logic               grp_last, keep_run;

    assign fire       = valid_q && out_ready;
    assign load_first = start && (state_q != RUN);
    assign load_next  = fire && !last_q && (state_q == RUN);

    // Seeds feed the chain on start; otherwise it continues from the stored lookahead pair.
    assign add_t0 = load_first ? seed0 : n0_q;
    assign add_t1 = load_first ? seed1 : n1_q;
    assign add_o0 = load_first ? 1'b0  : n0_ovf_q;
    assign add_o1 = load_first ? 1'b0  : n1_ovf_q;

    fib_group_adder #(
        .W     (W),
        .LANES (LANES)
    ) u_adder (
        .t0        (add_t0),
        .t1        (add_t1),
        .o0        (add_o0),
        .o1        (add_o1),
        .lane_term (lane_term),
        .lane_ovf  (lane_ovf),
        .nxt_t0    (nxt_t0),
        .nxt_t1    (nxt_t1),
        .nxt_o0    (nxt_o0),
        .nxt_o1    (nxt_o1)
    );

    // An overflow in the lookahead term closes this group so no empty group is ever emitted.
    always_comb begin
        keep_run = 1'b1;
        grp_keep = '0;
        grp_last = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_ovf[i]) begin
                keep_run = 1'b0;
            end
            grp_keep[i] = keep_run;
        end
        if (!STOP) begin
            grp_keep = '1;
        end else begin
            grp_last = (|lane_ovf) | nxt_o0;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        n0_d     = n0_q;
        n1_d     = n1_q;
        n0_ovf_d = n0_ovf_q;
        n1_ovf_d = n1_ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fire && last_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_first || load_next) begin
            valid_d  = 1'b1;
            data_d   = lane_term;
            keep_d   = grp_keep;
            last_d   = grp_last;
            n0_d     = nxt_t0;
            n1_d     = nxt_t1;
            n0_ovf_d = nxt_o0;
            n1_ovf_d = nxt_o1;
            idx_d    = load_first ? '0 : idx_q + IDX_W'(LANES);
            ovf_d    = STOP ? grp_last : ((|lane_ovf) || (load_next && ovf_q));
        end else if ((state_q == RUN) && fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            n0_q     <= '0;
            n1_q     <= '0;
            n0_ovf_q <= 1'b0;
            n1_ovf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            n0_q     <= n0_d;
            n1_q     <= n1_d;
            n0_ovf_q <= n0_ovf_d;
            n1_ovf_q <= n1_ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fibonacci_stream.sv
// Directed bench for fibonacci_stream: wrap mode with stalls and reset, stop mode
// with partial last groups, and the single-lane and seed-overflow corner cases.
module tb_fibonacci_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        start_a, valid_a, ready_a, last_a, ovf_a;
    logic [15:0] seed0_a, seed1_a, idx_a;
    logic [31:0] data_a;
    logic [1:0]  keep_a;

    logic        start_b, valid_b, ready_b, last_b, ovf_b;
    logic [15:0] seed0_b, seed1_b, idx_b;
    logic [63:0] data_b;
    logic [3:0]  keep_b;

    logic        start_c, valid_c, ready_c, last_c, ovf_c;
    logic [15:0] seed0_c, seed1_c, idx_c;
    logic [15:0] data_c;
    logic [0:0]  keep_c;

    logic        start_d, valid_d, ready_d, last_d, ovf_d;
    logic [15:0] seed0_d, seed1_d, idx_d;
    logic [31:0] data_d;
    logic [1:0]  keep_d;

    fibonacci_stream #(.W(16), .LANES(2), .STOP_ON_OVF(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed0(seed0_a), .seed1(seed1_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_keep(keep_a),
        .out_last(last_a), .out_idx(idx_a), .ovf(ovf_a)
    );

    fibonacci_stream #(.W(16), .LANES(4), .STOP_ON_OVF(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed0(seed0_b), .seed1(seed1_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_keep(keep_b),
        .out_last(last_b), .out_idx(idx_b), .ovf(ovf_b)
    );

    fibonacci_stream #(.W(16), .LANES(1), .STOP_ON_OVF(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .seed0(seed0_c), .seed1(seed1_c),
        .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c), .out_keep(keep_c),
        .out_last(last_c), .out_idx(idx_c), .ovf(ovf_c)
    );

    fibonacci_stream #(.W(16), .LANES(2), .STOP_ON_OVF(1)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .seed0(seed0_d), .seed1(seed1_d),
        .out_valid(valid_d), .out_ready(ready_d), .out_data(data_d), .out_keep(keep_d),
        .out_last(last_d), .out_idx(idx_d), .ovf(ovf_d)
    );

    typedef struct {
        logic        ready;
        logic        pulse_start;
        logic [15:0] exp_idx;
        logic [15:0] exp_lane0;
        logic [15:0] exp_lane1;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [17];
    int unsigned fib [0:31];
    logic [63:0] exp_b;
    int          base;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic pulse, input logic [15:0] s0, input logic [15:0] s1);
        ready_a = ready;
        start_a = pulse;
        seed0_a = s0;
        seed1_a = s1;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 0; ready_a = 0; seed0_a = 0; seed1_a = 0;
        start_b = 0; ready_b = 0; seed0_b = 0; seed1_b = 0;
        start_c = 0; ready_c = 0; seed0_c = 0; seed1_c = 0;
        start_d = 0; ready_d = 0; seed0_d = 0; seed1_d = 0;

        // Each row: outputs expected at this cycle, then ready/start driven for the next edge.
        vecs[0]  = '{1'b1, 1'b0, 16'd0,  16'd1,     16'd1,     1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'd2,  16'd2,     16'd3,     1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'd2,  16'd2,     16'd3,     1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'd2,  16'd2,     16'd3,     1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'd2,  16'd2,     16'd3,     1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'd4,  16'd5,     16'd8,     1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'd6,  16'd13,    16'd21,    1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'd8,  16'd34,    16'd55,    1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'd10, 16'd89,    16'd144,   1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'd12, 16'd233,   16'd377,   1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'd14, 16'd610,   16'd987,   1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'd16, 16'd1597,  16'd2584,  1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'd18, 16'd4181,  16'd6765,  1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'd20, 16'd10946, 16'd17711, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'd22, 16'd28657, 16'd46368, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 16'd24, 16'd9489,  16'd55857, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 16'd26, 16'd65346, 16'd55667, 1'b1};

        fib[0] = 0;
        fib[1] = 1;
        for (int k = 2; k < 32; k++) fib[k] = fib[k-1] + fib[k-2];

        repeat (2) @(negedge clk);
        checkOutput("reset valid", 64'(valid_a), 64'd0);
        checkOutput("reset data", 64'(data_a), 64'd0);
        checkOutput("reset keep", 64'(keep_a), 64'd0);
        checkOutput("reset last", 64'(last_a), 64'd0);
        checkOutput("reset idx", 64'(idx_a), 64'd0);
        checkOutput("reset ovf", 64'(ovf_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle valid", 64'(valid_a), 64'd0);

        applyStimulus(1'b1, 1'b1, 16'd1, 16'd1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checkOutput($sformatf("a row%0d valid", i), 64'(valid_a), 64'd1);
            checkOutput($sformatf("a row%0d idx", i), 64'(idx_a), 64'(vecs[i].exp_idx));
            checkOutput($sformatf("a row%0d data", i), 64'(data_a), 64'({vecs[i].exp_lane1, vecs[i].exp_lane0}));
            checkOutput($sformatf("a row%0d keep", i), 64'(keep_a), 64'd3);
            checkOutput($sformatf("a row%0d last", i), 64'(last_a), 64'd0);
            checkOutput($sformatf("a row%0d ovf", i), 64'(ovf_a), 64'(vecs[i].exp_ovf));
            applyStimulus(vecs[i].ready, vecs[i].pulse_start, 16'd100, 16'd200);
        end

        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'd1, 16'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 16'd1, 16'd1);
        end
        checkOutput("a pre-reset idx", 64'(idx_a), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("a midrun reset valid", 64'(valid_a), 64'd0);
        checkOutput("a midrun reset data", 64'(data_a), 64'd0);
        checkOutput("a midrun reset keep", 64'(keep_a), 64'd0);
        checkOutput("a midrun reset last", 64'(last_a), 64'd0);
        checkOutput("a midrun reset idx", 64'(idx_a), 64'd0);
        checkOutput("a midrun reset ovf", 64'(ovf_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("a idle after reset valid", 64'(valid_a), 64'd0);

        // Four lanes, stop mode: the overflow lands in lane 1 of the group at idx 24.
        ready_b = 1'b1; seed0_b = 16'd0; seed1_b = 16'd1; start_b = 1'b1;
        for (int g = 0; g < 7; g++) begin
            @(negedge clk);
            start_b = 1'b0;
            base = 4 * g;
            checkOutput($sformatf("b grp%0d valid", g), 64'(valid_b), 64'd1);
            checkOutput($sformatf("b grp%0d idx", g), 64'(idx_b), 64'(base));
            if (g < 6) begin
                exp_b = {fib[base+3][15:0], fib[base+2][15:0], fib[base+1][15:0], fib[base][15:0]};
                checkOutput($sformatf("b grp%0d data", g), data_b, exp_b);
                checkOutput($sformatf("b grp%0d keep", g), 64'(keep_b), 64'hF);
                checkOutput($sformatf("b grp%0d last", g), 64'(last_b), 64'd0);
                checkOutput($sformatf("b grp%0d ovf", g), 64'(ovf_b), 64'd0);
            end else begin
                checkOutput("b final lane0", 64'(data_b[15:0]), 64'd46368);
                checkOutput("b final keep", 64'(keep_b), 64'h1);
                checkOutput("b final last", 64'(last_b), 64'd1);
                checkOutput("b final ovf", 64'(ovf_b), 64'd1);
            end
        end
        @(negedge clk);
        checkOutput("b done valid", 64'(valid_b), 64'd0);
        @(negedge clk);
        checkOutput("b done hold valid", 64'(valid_b), 64'd0);
        checkOutput("b done ovf sticky", 64'(ovf_b), 64'd1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checkOutput("b restart valid", 64'(valid_b), 64'd1);
        checkOutput("b restart idx", 64'(idx_b), 64'd0);
        checkOutput("b restart data", data_b, 64'h0002_0001_0001_0000);
        checkOutput("b restart keep", 64'(keep_b), 64'hF);
        checkOutput("b restart last", 64'(last_b), 64'd0);
        checkOutput("b restart ovf", 64'(ovf_b), 64'd0);

        // One lane, stop mode: seed1 is in range, so it gets its own final group.
        ready_c = 1'b1; seed0_c = 16'd40000; seed1_c = 16'd30000; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        checkOutput("c grp0 valid", 64'(valid_c), 64'd1);
        checkOutput("c grp0 data", 64'(data_c), 64'd40000);
        checkOutput("c grp0 idx", 64'(idx_c), 64'd0);
        checkOutput("c grp0 keep", 64'(keep_c), 64'd1);
        checkOutput("c grp0 last", 64'(last_c), 64'd0);
        checkOutput("c grp0 ovf", 64'(ovf_c), 64'd0);
        @(negedge clk);
        checkOutput("c grp1 valid", 64'(valid_c), 64'd1);
        checkOutput("c grp1 data", 64'(data_c), 64'd30000);
        checkOutput("c grp1 idx", 64'(idx_c), 64'd1);
        checkOutput("c grp1 keep", 64'(keep_c), 64'd1);
        checkOutput("c grp1 last", 64'(last_c), 64'd1);
        checkOutput("c grp1 ovf", 64'(ovf_c), 64'd1);
        @(negedge clk);
        checkOutput("c done valid", 64'(valid_c), 64'd0);

        // Two lanes, stop mode, seeds whose sum overflows: one group, held through a stall.
        ready_d = 1'b0; seed0_d = 16'd40000; seed1_d = 16'd30000; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        checkOutput("d grp valid", 64'(valid_d), 64'd1);
        checkOutput("d grp data", 64'(data_d), 64'({16'd30000, 16'd40000}));
        checkOutput("d grp idx", 64'(idx_d), 64'd0);
        checkOutput("d grp keep", 64'(keep_d), 64'd3);
        checkOutput("d grp last", 64'(last_d), 64'd1);
        checkOutput("d grp ovf", 64'(ovf_d), 64'd1);
        @(negedge clk);
        checkOutput("d stall valid", 64'(valid_d), 64'd1);
        checkOutput("d stall data", 64'(data_d), 64'({16'd30000, 16'd40000}));
        ready_d = 1'b1;
        @(negedge clk);
        checkOutput("d done valid", 64'(valid_d), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
